// File: rtl/mor1kx_icache_refill_ctrl_pkg.sv
// Shared definitions for the icache refill controller: FSM encoding and
// line/word geometry helpers.
package mor1kx_icache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_BURST = 3'b010,
    ST_DONE  = 3'b100
  } refill_state_t;

  // Bus addresses are word aligned; the word offset inside a line starts here.
  localparam int WORD_LSB = 2;

  function automatic int refill_words(input int block_width);
    return 1 << (block_width - WORD_LSB);
  endfunction

endpackage

// File: rtl/mor1kx_refill_timeout.sv
// Bus-stall watchdog for cache refills: counts enabled cycles since the last
// clear and flags the cycle in which the limit would be reached.
module mor1kx_refill_timeout #(
  parameter int TIMEOUT = 255,
  parameter int WIDTH   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LAST_I);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Expiry is flagged one stall early so the abort lands on the TIMEOUT-th stall.
  assign expire = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mor1kx_icache_refill_ctrl.sv
// Instruction cache line refill sequencer: critical-word-first wrapping burst
// on the instruction bus, one icache write per returned word, abort on error/timeout.
module mor1kx_icache_refill_ctrl
  import mor1kx_icache_refill_ctrl_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5,
  parameter int OPTION_BUS_TIMEOUT        = 255,
  parameter int TIMEOUT_WIDTH             = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            refill_req_i,
  input  logic                            refill_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_match_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            ic_imem_err_o,
  output logic                            ibus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_burst_o,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i,
  output logic                            busy_o,
  output logic                            timeout_o,
  output logic [2:0]                      dbg_state
);

  // Bus handshake: ibus_req_o is held with a stable ibus_adr_o until the
  // slave answers with ibus_ack_i (data valid) or ibus_err_i (terminates).
  localparam int AW = OPTION_OPERAND_WIDTH;
  localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int WW = BW - WORD_LSB;
  localparam int NW = refill_words(BW);
  localparam logic [WW-1:0] LAST_BEAT = WW'(NW - 1);

  refill_state_t   state_q, state_d;
  logic [AW-1:BW]  base_q;
  logic [WW-1:0]   start_q;
  logic [WW-1:0]   beat_q;
  logic [WW-1:0]   word;
  logic [AW-1:0]   cur_adr;
  logic            cancel_q, cancel_d;
  logic            we_q, err_q, timeout_q;
  logic [AW-1:0]   wradr_q, wrdat_q;
  logic            accept, beat_ack, write, abort, quiet;
  logic            tmo_clr, tmo_en, tmo_expire;
  logic            in_burst;
  logic            unused_adr_lsb;

  assign unused_adr_lsb = ^cpu_adr_match_i[WORD_LSB-1:0];

  mor1kx_refill_timeout #(
    .TIMEOUT (OPTION_BUS_TIMEOUT),
    .WIDTH   (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Word offset wraps inside the line; the line base never moves.
  always_comb begin
    word    = start_q + beat_q;
    cur_adr = {base_q, word, {WORD_LSB{1'b0}}};
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    accept   = 1'b0;
    beat_ack = 1'b0;
    write    = 1'b0;
    abort    = 1'b0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;
    quiet    = cancel_q | ~refill_i;
    case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        tmo_clr  = 1'b1;
        if (refill_req_i && !err_q) begin
          accept  = 1'b1;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // Once the cache leaves REFILL, finish the open beat without writing it.
        cancel_d = quiet;
        if (ibus_err_i || (tmo_expire && !ibus_ack_i)) begin
          abort   = ~quiet;
          state_d = ST_IDLE;
        end else if (ibus_ack_i) begin
          beat_ack = 1'b1;
          tmo_clr  = 1'b1;
          write    = ~quiet;
          if (quiet) begin
            state_d = ST_IDLE;
          end else if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_DONE: begin
        cancel_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cancel_q  <= 1'b0;
      base_q    <= '0;
      start_q   <= '0;
      beat_q    <= '0;
      we_q      <= 1'b0;
      wradr_q   <= '0;
      wrdat_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      we_q     <= write;
      err_q    <= abort;
      if (accept) begin
        base_q    <= cpu_adr_match_i[AW-1:BW];
        start_q   <= cpu_adr_match_i[BW-1:WORD_LSB];
        beat_q    <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (beat_ack) beat_q <= beat_q + 1'b1;
        if (abort && !ibus_err_i) timeout_q <= 1'b1;
      end
      if (write) begin
        wradr_q <= cur_adr;
        wrdat_q <= ibus_dat_i;
      end
    end
  end

  assign in_burst      = (state_q == ST_BURST);
  assign ibus_req_o    = in_burst;
  assign ibus_adr_o    = in_burst ? cur_adr : '0;
  assign ibus_burst_o  = in_burst && (beat_q != LAST_BEAT);
  assign busy_o        = (state_q != ST_IDLE);
  assign we_o          = we_q;
  assign wradr_o       = wradr_q;
  assign wrdat_o       = wrdat_q;
  assign ic_imem_err_o = err_q;
  assign timeout_o     = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mor1kx_icache_refill_ctrl.sv
// Bench for the icache refill controller: a bus responder drives refills and a
// line-geometry reference model supplies the expected addresses and writes.
module tb_mor1kx_icache_refill_ctrl;

  localparam int TMO = 4;
  localparam int NW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        refill_req = 1'b0, refill = 1'b0, ibus_ack = 1'b0, ibus_err = 1'b0;
  logic [31:0] cpu_adr = '0, ibus_dat = '0;
  logic [31:0] wradr, wrdat, ibus_adr;
  logic        we, imem_err, ibus_req, ibus_burst, busy, timeout;
  logic [2:0]  dbg_state;

  logic        b_req = 1'b0, b_refill = 1'b0, b_ack = 1'b0, b_err = 1'b0;
  logic [31:0] b_adr = '0, b_dat = '0;
  logic [31:0] b_wradr, b_wrdat, b_ibus_adr;
  logic        b_we, b_imem_err, b_ibus_req, b_ibus_burst, b_busy, b_timeout;
  logic [2:0]  b_dbg_state;

  mor1kx_icache_refill_ctrl #(
    .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5),
    .OPTION_BUS_TIMEOUT(TMO), .TIMEOUT_WIDTH(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .refill_req_i(refill_req), .refill_i(refill),
    .cpu_adr_match_i(cpu_adr), .wradr_o(wradr), .wrdat_o(wrdat), .we_o(we),
    .ic_imem_err_o(imem_err), .ibus_req_o(ibus_req), .ibus_adr_o(ibus_adr),
    .ibus_burst_o(ibus_burst), .ibus_ack_i(ibus_ack), .ibus_err_i(ibus_err),
    .ibus_dat_i(ibus_dat), .busy_o(busy), .timeout_o(timeout), .dbg_state(dbg_state)
  );

  mor1kx_icache_refill_ctrl #(
    .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4),
    .OPTION_BUS_TIMEOUT(0), .TIMEOUT_WIDTH(8)
  ) u_dut_bw4 (
    .clk(clk), .rst_n(rst_n), .refill_req_i(b_req), .refill_i(b_refill),
    .cpu_adr_match_i(b_adr), .wradr_o(b_wradr), .wrdat_o(b_wrdat), .we_o(b_we),
    .ic_imem_err_o(b_imem_err), .ibus_req_o(b_ibus_req), .ibus_adr_o(b_ibus_adr),
    .ibus_burst_o(b_ibus_burst), .ibus_ack_i(b_ack), .ibus_err_i(b_err),
    .ibus_dat_i(b_dat), .busy_o(b_busy), .timeout_o(b_timeout), .dbg_state(b_dbg_state)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_bus_adr[$], obs_wr_adr[$], obs_wr_dat[$], drv_dat[$];
  logic        obs_burst[$];
  int          obs_we_neg[$], ack_neg[$];
  int          err_pulses, err_neg, err_drv_neg, done_neg, busy_after_err, req_at_err, max_we_run;
  logic [2:0]  rst_obs;

  // Reference model: i-th beat of a critical-word-first wrapping line fill.
  function automatic logic [31:0] line_adr(input logic [31:0] miss, input int bw, input int i);
    int nw = 1 << (bw - 2);
    logic [31:0] base = miss & ~((32'd1 << bw) - 32'd1);
    int start = int'((miss >> 2) & 32'(nw - 1));
    return base + 32'(((start + i) % nw) * 4);
  endfunction

  task automatic build_exp(input logic [31:0] miss, input int bw, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(line_adr(miss, bw, i));
  endtask

  function automatic int gap_of(input int gap);
    return (gap < 0) ? int'($urandom_range(0, TMO - 1)) : gap;
  endfunction

  // Bus responder plus monitor for one refill on the BW=5 instance.
  task automatic drive_refill(input logic [31:0] miss, input int gap, input int err_beat,
                              input bit err_with_ack, input int stall_beat,
                              input int drop_beat, input int rst_beat);
    int cyc, beats, wait_n, run;
    bit post_err;
    obs_bus_adr.delete(); obs_burst.delete(); obs_wr_adr.delete(); obs_wr_dat.delete();
    drv_dat.delete(); obs_we_neg.delete(); ack_neg.delete();
    err_pulses = 0; err_neg = -1; err_drv_neg = -1; done_neg = -1;
    busy_after_err = -1; req_at_err = -1; max_we_run = 0; rst_obs = 3'b111;
    @(negedge clk);
    refill_req = 1'b1; refill = 1'b1; cpu_adr = miss; ibus_ack = 1'b0; ibus_err = 1'b0;
    cyc = 0; beats = 0; run = 0; post_err = 1'b0; wait_n = gap_of(gap);
    while (1) begin
      @(negedge clk);
      cyc++;
      ibus_ack = 1'b0;
      ibus_err = 1'b0;
      if (we) begin
        obs_wr_adr.push_back(wradr); obs_wr_dat.push_back(wrdat); obs_we_neg.push_back(cyc);
        run++;
        if (run > max_we_run) max_we_run = run;
        if (obs_wr_adr.size() == NW) refill_req = 1'b0;
      end else begin
        run = 0;
      end
      if (imem_err) begin
        err_pulses++; err_neg = cyc; req_at_err = int'(ibus_req); post_err = 1'b1;
      end else if (post_err) begin
        busy_after_err = int'(busy); refill_req = 1'b0; post_err = 1'b0;
      end
      if (!busy && !imem_err) begin
        done_neg = cyc; refill_req = 1'b0;
        break;
      end
      if (ibus_req) begin
        if (rst_beat == beats) begin
          #2 rst_n = 1'b0;
          #1 rst_obs = {we, ibus_req, busy};
          refill_req = 1'b0;
          break;
        end
        if (drop_beat == beats) begin
          refill = 1'b0; refill_req = 1'b0;
        end
        if (stall_beat >= 0 && beats >= stall_beat) begin
          wait_n = 0;
        end else if (wait_n > 0) begin
          wait_n--;
        end else begin
          obs_bus_adr.push_back(ibus_adr); obs_burst.push_back(ibus_burst);
          if (err_beat == beats) begin
            ibus_err = 1'b1; ibus_ack = err_with_ack; err_drv_neg = cyc;
          end else begin
            ibus_dat = $urandom; drv_dat.push_back(ibus_dat);
            ibus_ack = 1'b1; ack_neg.push_back(cyc); beats++;
          end
          wait_n = gap_of(gap);
        end
      end
      if (cyc > 300) begin
        total++; bad++;
        $display("FAIL refill_bound: still busy after %0d cycles, want idle", cyc);
        refill_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({we, imem_err, ibus_req, ibus_burst, busy, timeout} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {we, imem_err, ibus_req, ibus_burst, busy, timeout});
    end
    total++;
    if (ibus_adr !== 32'h0 || wradr !== 32'h0 || wrdat !== 32'h0) begin
      bad++; $display("FAIL reset_data: got %h/%h/%h want 0", ibus_adr, wradr, wrdat);
    end
    total++;
    if (!$onehot(dbg_state) || !$onehot(b_dbg_state) || b_busy !== 1'b0) begin
      bad++; $display("FAIL reset_state: got %b/%b busy %b want onehot, 0", dbg_state, b_dbg_state, b_busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_every_cycle();
    drive_refill(32'h0000_1014, 0, -1, 1'b0, -1, -1, -1);
    build_exp(32'h0000_1014, 5, NW);
    total++;
    if (obs_bus_adr.size() != NW || obs_wr_adr.size() != NW) begin
      bad++; $display("FAIL ec_counts: got beats %0d writes %0d want %0d", obs_bus_adr.size(), obs_wr_adr.size(), NW);
    end
    for (int i = 0; i < obs_bus_adr.size() && i < NW; i++) begin
      total++;
      if (obs_bus_adr[i] !== exp_q[i] || obs_burst[i] !== (i != NW - 1)) begin
        bad++; $display("FAIL ec_bus[%0d]: got %h burst %b want %h burst %b", i, obs_bus_adr[i], obs_burst[i], exp_q[i], i != NW - 1);
      end
    end
    for (int i = 0; i < obs_wr_adr.size() && i < NW; i++) begin
      total++;
      if (obs_wr_adr[i] !== exp_q[i] || obs_wr_dat[i] !== drv_dat[i] || obs_we_neg[i] != ack_neg[i] + 1) begin
        bad++; $display("FAIL ec_write[%0d]: got %h/%h at %0d want %h/%h at %0d", i, obs_wr_adr[i], obs_wr_dat[i], obs_we_neg[i], exp_q[i], drv_dat[i], ack_neg[i] + 1);
      end
    end
    total++;
    if (done_neg != 10 || max_we_run != NW || err_pulses != 0) begin
      bad++; $display("FAIL ec_timing: got idle@%0d run %0d errs %0d want 10 %0d 0", done_neg, max_we_run, err_pulses, NW);
    end
  endtask

  task automatic test_slow_ack(input int gap);
    drive_refill(32'h0000_1014, gap, -1, 1'b0, -1, -1, -1);
    build_exp(32'h0000_1014, 5, NW);
    total++;
    if (obs_wr_adr.size() != NW || max_we_run != 1 || err_pulses != 0) begin
      bad++; $display("FAIL slow%0d_counts: got writes %0d run %0d errs %0d want %0d 1 0", gap, obs_wr_adr.size(), max_we_run, err_pulses, NW);
    end
    for (int i = 0; i < obs_wr_adr.size() && i < NW; i++) begin
      total++;
      if (obs_wr_adr[i] !== exp_q[i] || obs_wr_dat[i] !== drv_dat[i] || obs_we_neg[i] != ack_neg[i] + 1) begin
        bad++; $display("FAIL slow%0d_write[%0d]: got %h/%h at %0d want %h/%h at %0d", gap, i, obs_wr_adr[i], obs_wr_dat[i], obs_we_neg[i], exp_q[i], drv_dat[i], ack_neg[i] + 1);
      end
    end
  endtask

  task automatic test_bus_error();
    drive_refill(32'h0000_1014, 0, 3, 1'b1, -1, -1, -1);
    build_exp(32'h0000_1014, 5, 3);
    total++;
    if (obs_wr_adr.size() != 3 || obs_bus_adr.size() != 4) begin
      bad++; $display("FAIL err_counts: got writes %0d beats %0d want 3 4", obs_wr_adr.size(), obs_bus_adr.size());
    end else begin
      total++;
      if (obs_bus_adr[3] !== 32'h0000_1000) begin
        bad++; $display("FAIL err_wrap_adr: got %h want 00001000", obs_bus_adr[3]);
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_wr_adr[i] !== exp_q[i] || obs_wr_dat[i] !== drv_dat[i]) begin
          bad++; $display("FAIL err_write[%0d]: got %h/%h want %h/%h", i, obs_wr_adr[i], obs_wr_dat[i], exp_q[i], drv_dat[i]);
        end
      end
    end
    total++;
    if (err_pulses != 1 || err_neg != err_drv_neg + 1 || req_at_err != 0 || busy_after_err != 0) begin
      bad++; $display("FAIL err_pulse: got n=%0d at %0d req %0d busy_next %0d want 1 at %0d 0 0", err_pulses, err_neg, req_at_err, busy_after_err, err_drv_neg + 1);
    end
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL err_timeout_flag: got %b want 0", timeout);
    end
  endtask

  task automatic test_timeout();
    drive_refill(32'h0000_1014, 0, -1, 1'b0, 1, -1, -1);
    total++;
    if (obs_wr_adr.size() != 1 || ack_neg.size() != 1) begin
      bad++; $display("FAIL tmo_writes: got %0d acks %0d want 1 1", obs_wr_adr.size(), ack_neg.size());
    end else begin
      total++;
      if (err_pulses != 1 || err_neg != ack_neg[0] + TMO + 1 || busy_after_err != 0) begin
        bad++; $display("FAIL tmo_abort: got n=%0d at %0d busy_next %0d want 1 at %0d 0", err_pulses, err_neg, busy_after_err, ack_neg[0] + TMO + 1);
      end
    end
    total++;
    if (timeout !== 1'b1) begin
      bad++; $display("FAIL tmo_flag_set: got %b want 1", timeout);
    end
    drive_refill(32'h0000_3000, 0, -1, 1'b0, -1, -1, -1);
    total++;
    if (timeout !== 1'b0 || obs_wr_adr.size() != NW || err_pulses != 0) begin
      bad++; $display("FAIL tmo_flag_clear: got %b writes %0d errs %0d want 0 %0d 0", timeout, obs_wr_adr.size(), err_pulses, NW);
    end
  endtask

  task automatic test_refill_drop();
    drive_refill(32'h0000_5018, 0, -1, 1'b0, -1, 3, -1);
    build_exp(32'h0000_5018, 5, 3);
    total++;
    if (obs_wr_adr.size() != 3 || ack_neg.size() != 4 || err_pulses != 0 || done_neg < 0) begin
      bad++; $display("FAIL drop_counts: got writes %0d acks %0d errs %0d idle@%0d want 3 4 0 >=0", obs_wr_adr.size(), ack_neg.size(), err_pulses, done_neg);
    end
    for (int i = 0; i < obs_wr_adr.size() && i < 3; i++) begin
      total++;
      if (obs_wr_adr[i] !== exp_q[i]) begin
        bad++; $display("FAIL drop_write[%0d]: got %h want %h", i, obs_wr_adr[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    drive_refill(32'h0000_1014, 0, -1, 1'b0, -1, -1, 5);
    total++;
    if (rst_obs !== 3'b000) begin
      bad++; $display("FAIL rst_async: got we/req/busy %b want 000", rst_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_refill(32'h0000_4038, 0, -1, 1'b0, -1, -1, -1);
    build_exp(32'h0000_4038, 5, NW);
    total++;
    if (obs_bus_adr.size() != NW || obs_wr_adr.size() != NW) begin
      bad++; $display("FAIL rst_restart_counts: got %0d/%0d want %0d", obs_bus_adr.size(), obs_wr_adr.size(), NW);
    end
    for (int i = 0; i < obs_bus_adr.size() && i < NW; i++) begin
      total++;
      if (obs_bus_adr[i] !== exp_q[i]) begin
        bad++; $display("FAIL rst_restart_adr[%0d]: got %h want %h", i, obs_bus_adr[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] miss;
    for (int n = 0; n < 4; n++) begin
      miss = $urandom & 32'hFFFF_FFFC;
      drive_refill(miss, -1, -1, 1'b0, -1, -1, -1);
      build_exp(miss, 5, NW);
      total++;
      if (obs_wr_adr.size() != NW || obs_bus_adr.size() != NW || err_pulses != 0) begin
        bad++; $display("FAIL rand%0d_counts: got %0d/%0d errs %0d want %0d 0", n, obs_bus_adr.size(), obs_wr_adr.size(), err_pulses, NW);
      end
      for (int i = 0; i < obs_wr_adr.size() && i < NW && i < obs_bus_adr.size(); i++) begin
        total++;
        if (obs_bus_adr[i] !== exp_q[i] || obs_wr_adr[i] !== exp_q[i] || obs_wr_dat[i] !== drv_dat[i]) begin
          bad++; $display("FAIL rand%0d[%0d]: got %h/%h/%h want %h/%h", n, i, obs_bus_adr[i], obs_wr_adr[i], obs_wr_dat[i], exp_q[i], drv_dat[i]);
        end
      end
    end
  endtask

  task automatic test_bw4_wrap();
    logic [31:0] b_obs_adr[$], b_obs_wr[$], b_drv[$], b_obs_dat[$];
    logic        b_obs_burst[$];
    int cyc = 0, acks = 0, stall = 0, errs = 0;
    build_exp(32'h0000_2008, 4, 4);
    @(negedge clk);
    b_req = 1'b1; b_refill = 1'b1; b_adr = 32'h0000_2008;
    while (1) begin
      @(negedge clk);
      cyc++;
      b_ack = 1'b0;
      if (b_we) begin
        b_obs_wr.push_back(b_wradr); b_obs_dat.push_back(b_wrdat);
        if (b_obs_wr.size() == 4) b_req = 1'b0;
      end
      if (b_imem_err) errs++;
      if (!b_busy) break;
      if (b_ibus_req) begin
        if (acks == 2 && stall < 20) begin
          stall++;
        end else begin
          b_obs_adr.push_back(b_ibus_adr); b_obs_burst.push_back(b_ibus_burst);
          b_dat = $urandom; b_drv.push_back(b_dat); b_ack = 1'b1; acks++;
        end
      end
      if (cyc > 100) begin
        total++; bad++; $display("FAIL bw4_bound: still busy after %0d cycles, want idle", cyc);
        b_req = 1'b0;
        break;
      end
    end
    total++;
    if (b_obs_adr.size() != 4 || b_obs_wr.size() != 4 || errs != 0 || b_timeout !== 1'b0) begin
      bad++; $display("FAIL bw4_counts: got beats %0d writes %0d errs %0d tmo %b want 4 4 0 0", b_obs_adr.size(), b_obs_wr.size(), errs, b_timeout);
    end
    for (int i = 0; i < 4 && i < b_obs_adr.size() && i < b_obs_wr.size(); i++) begin
      total++;
      if (b_obs_adr[i] !== exp_q[i] || b_obs_burst[i] !== (i != 3) || b_obs_wr[i] !== exp_q[i] || b_obs_dat[i] !== b_drv[i]) begin
        bad++; $display("FAIL bw4_beat[%0d]: got %h burst %b wr %h/%h want %h burst %b wr %h", i, b_obs_adr[i], b_obs_burst[i], b_obs_wr[i], b_obs_dat[i], exp_q[i], i != 3, b_drv[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_every_cycle();
    test_slow_ack(2);
    test_slow_ack(3);
    test_bus_error();
    test_timeout();
    test_refill_drop();
    test_reset_mid_burst();
    test_random();
    test_bw4_wrap();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
